// File: rtl/trace_port_pkg.sv
// Shared constants, width encodings and state type for the trace-port transmitter.
package trace_port_pkg;

  localparam logic [15:0] SYNC_LO_HW  = 16'hFFFF;
  localparam logic [15:0] SYNC_HI_HW  = 16'h7FFF;
  localparam logic [15:0] HALFSYNC_HW = 16'h7FFF;

  typedef enum logic [1:0] {
    WIDTH_1 = 2'b00,
    WIDTH_2 = 2'b01,
    WIDTH_4 = 2'b10
  } width_e;

  typedef enum logic [1:0] {
    ST_SYNC_LO,
    ST_SYNC_HI,
    ST_DATA,
    ST_HALFSYNC
  } tx_state_e;

  // Both 10 and 11 on the port select the 4-lane mode.
  function automatic width_e decode_width(input logic [1:0] pw);
    if (pw[1])      return WIDTH_4;
    else if (pw[0]) return WIDTH_2;
    else            return WIDTH_1;
  endfunction

  // Index of the final beat of a halfword for a given lane width.
  function automatic logic [3:0] last_beat(input width_e w);
    case (w)
      WIDTH_1: return 4'd15;
      WIDTH_2: return 4'd7;
      default: return 4'd3;
    endcase
  endfunction

endpackage

// File: rtl/trace_port_tx_if.sv
// Valid/ready halfword handshake feeding the trace-port transmitter.
interface trace_port_tx_if;
  logic [15:0] dataIn;
  logic        dataValid;
  logic        dataReady;

  modport master (output dataIn, output dataValid, input dataReady);
  modport slave  (input dataIn, input dataValid, output dataReady);
endinterface

// File: rtl/trace_port_serializer.sv
// Beat sequencer: two clock cycles per beat, data updates in phase A and the
// trace clock toggles in phase B, so data is stable a full cycle around each edge.
module trace_port_serializer
  import trace_port_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  port_width,
  input  logic [15:0] load_hw,
  output logic        boundary,
  output logic [3:0]  trace_dout,
  output logic        trace_clk
);

  logic        phase_b;
  logic [3:0]  beat;
  width_e      width_q;
  width_e      width_new;
  logic [15:0] shreg;

  assign width_new = decode_width(port_width);
  assign boundary  = !phase_b && (beat == 4'd0);

  function automatic logic [3:0] lanes(input logic [15:0] s, input width_e w);
    case (w)
      WIDTH_1: return {3'b000, s[0]};
      WIDTH_2: return {2'b00, s[1:0]};
      default: return s[3:0];
    endcase
  endfunction

  function automatic logic [15:0] shift_out(input logic [15:0] s, input width_e w);
    case (w)
      WIDTH_1: return s >> 1;
      WIDTH_2: return s >> 2;
      default: return s >> 4;
    endcase
  endfunction

  // Phase/beat sequencing, shifter load at the boundary and lane output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_b    <= 1'b0;
      beat       <= 4'd0;
      width_q    <= WIDTH_1;
      shreg      <= 16'h0000;
      trace_dout <= 4'h0;
      trace_clk  <= 1'b0;
    end else if (phase_b) begin
      trace_clk <= ~trace_clk;
      phase_b   <= 1'b0;
    end else begin
      phase_b <= 1'b1;
      if (beat == 4'd0) begin
        width_q    <= width_new;
        trace_dout <= lanes(load_hw, width_new);
        shreg      <= shift_out(load_hw, width_new);
        beat       <= 4'd1;
      end else begin
        trace_dout <= lanes(shreg, width_q);
        shreg      <= shift_out(shreg, width_q);
        beat       <= (beat == last_beat(width_q)) ? 4'd0 : beat + 4'd1;
      end
    end
  end

endmodule

// File: rtl/trace_port_tx.sv
// Trace-port transmitter top: holding register, sync scheduling and selection
// of the halfword that the serializer loads at each halfword boundary.
module trace_port_tx
  import trace_port_pkg::*;
#(
  parameter int SYNC_INTERVAL = 64
) (
  input  logic            clkIn,
  input  logic            rstIn,
  input  logic [1:0]      portWidth,
  trace_port_tx_if.slave  data_if,
  output logic [3:0]      traceDout,
  output logic            traceClk,
  output logic            txInd,
  output logic            syncInd
);

  localparam int CW = $clog2(SYNC_INTERVAL + 1);

  tx_state_e   state;
  tx_state_e   next_state;
  logic [15:0] load_hw;
  logic [15:0] hold_q;
  logic        hold_full;
  logic        active;
  logic        sync_pending;
  logic [CW-1:0] data_count;
  logic        boundary;
  logic        accept;

  assign data_if.dataReady = active && !hold_full;
  assign accept            = data_if.dataValid && data_if.dataReady;

  // Boundary choice: the sync pair is never split, then pending sync, data, halfsync filler.
  always_comb begin
    next_state = ST_HALFSYNC;
    load_hw    = HALFSYNC_HW;
    if (state == ST_SYNC_LO)  next_state = ST_SYNC_HI;
    else if (sync_pending)    next_state = ST_SYNC_LO;
    else if (hold_full)       next_state = ST_DATA;
    case (next_state)
      ST_SYNC_LO: load_hw = SYNC_LO_HW;
      ST_SYNC_HI: load_hw = SYNC_HI_HW;
      ST_DATA:    load_hw = hold_q;
      default:    load_hw = HALFSYNC_HW;
    endcase
  end

  // One-entry holding register; a fresh accept wins over the load that frees it.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      hold_q    <= 16'h0000;
      hold_full <= 1'b0;
      active    <= 1'b0;
    end else begin
      active <= 1'b1;
      if (accept) begin
        hold_q    <= data_if.dataIn;
        hold_full <= 1'b1;
      end else if (boundary && next_state == ST_DATA) begin
        hold_full <= 1'b0;
      end
    end
  end

  // State register, sync scheduler and start-of-halfword pulses.
  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state        <= ST_HALFSYNC;
      sync_pending <= 1'b1;
      data_count   <= '0;
      txInd        <= 1'b0;
      syncInd      <= 1'b0;
    end else begin
      txInd   <= 1'b0;
      syncInd <= 1'b0;
      if (boundary) begin
        state <= next_state;
        case (next_state)
          ST_SYNC_LO: begin
            sync_pending <= 1'b0;
            data_count   <= '0;
            syncInd      <= 1'b1;
          end
          ST_DATA: begin
            txInd      <= 1'b1;
            data_count <= data_count + 1'b1;
            if (data_count == CW'(SYNC_INTERVAL - 1)) sync_pending <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  trace_port_serializer u_serializer (
    .clk        (clkIn),
    .rst_n      (rstIn),
    .port_width (portWidth),
    .load_hw    (load_hw),
    .boundary   (boundary),
    .trace_dout (traceDout),
    .trace_clk  (traceClk)
  );

endmodule

// File: tb/tb_trace_port_tx.sv
// Testbench for trace_port_tx: a halfword-level reference model predicts every
// output on every cycle; directed sections add hand-computed expectations.
module tb_trace_port_tx;

  localparam int SYNC_IV = 2;

  logic       clkIn;
  logic       rstIn;
  logic [1:0] portWidth;
  logic [3:0] traceDout;
  logic       traceClk;
  logic       txInd;
  logic       syncInd;

  trace_port_tx_if dif ();

  trace_port_tx #(.SYNC_INTERVAL(SYNC_IV)) dut (
    .clkIn     (clkIn),
    .rstIn     (rstIn),
    .portWidth (portWidth),
    .data_if   (dif),
    .traceDout (traceDout),
    .traceClk  (traceClk),
    .txInd     (txInd),
    .syncInd   (syncInd)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 0;
  int cyc    = 0;
  int tx_times[$];

  // Reference model: which halfword is on the wire, at which offset, and what it must show.
  typedef enum {K_SYNC_LO, K_SYNC_HI, K_DATA, K_HALF} kind_e;
  kind_e       m_kind;
  int          m_pos, m_len, m_w, m_edges, m_count;
  bit          m_started, m_pend, m_hold_full, m_acc;
  logic [15:0] m_hold, m_hw;
  logic [3:0]  e_dout;
  logic        e_clk, e_tx, e_sync, e_ready;

  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  always @(posedge clkIn) cyc++;

  always @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      m_kind = K_HALF; m_pos = 0; m_len = 32; m_w = 1; m_edges = 0; m_count = 0;
      m_started = 0; m_pend = 1; m_hold_full = 0; m_hold = 16'h0; m_hw = 16'h0;
      e_dout = 4'h0; e_clk = 0; e_tx = 0; e_sync = 0; e_ready = 0;
    end else begin
      m_acc  = dif.dataValid && m_started && !m_hold_full;
      e_tx   = 0;
      e_sync = 0;
      if (m_pos == 0) begin
        if (m_kind == K_SYNC_LO)  m_kind = K_SYNC_HI;
        else if (m_pend)          m_kind = K_SYNC_LO;
        else if (m_hold_full)     m_kind = K_DATA;
        else                      m_kind = K_HALF;
        m_w   = (portWidth == 2'd0) ? 1 : (portWidth == 2'd1) ? 2 : 4;
        m_len = 2 * (16 / m_w);
        case (m_kind)
          K_SYNC_LO: begin m_hw = 16'hFFFF; m_pend = 0; m_count = 0; e_sync = 1; end
          K_DATA: begin
            m_hw = m_hold; m_hold_full = 0; e_tx = 1; m_count++;
            if (m_count == SYNC_IV) m_pend = 1;
          end
          default: m_hw = 16'h7FFF;
        endcase
      end
      e_dout = 4'((int'(m_hw) >> ((m_pos / 2) * m_w)) & ((1 << m_w) - 1));
      m_pos++;
      if (m_pos == m_len) m_pos = 0;
      if (m_acc) begin m_hold = dif.dataIn; m_hold_full = 1; end
      m_started = 1;
      m_edges++;
      e_clk   = ((m_edges / 2) % 2) == 1;
      e_ready = m_started && !m_hold_full;
    end
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_output();
    cmp("traceDout", 32'(traceDout), 32'(e_dout));
    cmp("traceClk",  32'(traceClk),  32'(e_clk));
    cmp("txInd",     32'(txInd),     32'(e_tx));
    cmp("syncInd",   32'(syncInd),   32'(e_sync));
    cmp("dataReady", 32'(dif.dataReady), 32'(e_ready));
  endtask

  // Every cycle, away from the active edge, the DUT must agree with the model.
  always @(negedge clkIn) if (chk_en) check_output();

  always @(negedge clkIn) if (rstIn && txInd) tx_times.push_back(cyc);

  // Offer one halfword and hold it until the handshake completes (bounded).
  task automatic apply_stimulus(input logic [15:0] w);
    bit ok = 0;
    bit got;
    dif.dataIn    = w;
    dif.dataValid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      got = dif.dataReady;
      @(negedge clkIn);
      if (got) begin ok = 1; break; end
    end
    dif.dataValid = 1'b0;
    cmp("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic wait_tx(input int limit);
    for (int i = 0; i < limit && !txInd; i++) @(negedge clkIn);
    cmp("tx_seen", 32'(txInd), 32'd1);
  endtask

  task automatic async_reset();
    #3 rstIn = 1'b0;
    #1;
    cmp("rst_async_dout",  32'(traceDout), 32'd0);
    cmp("rst_async_clk",   32'(traceClk),  32'd0);
    cmp("rst_async_ready", 32'(dif.dataReady), 32'd0);
    @(negedge clkIn);
    @(negedge clkIn);
    rstIn = 1'b1;
  endtask

  initial begin
    rstIn = 1'b0; portWidth = 2'd0; dif.dataValid = 1'b0; dif.dataIn = 16'h0;
    repeat (3) @(negedge clkIn);
    chk_en = 1;
    cmp("rst_txInd",   32'(txInd),   32'd0);
    cmp("rst_syncInd", 32'(syncInd), 32'd0);

    // Reset release with 1-bit port and no data: full sync then halfsync.
    rstIn = 1'b1;
    @(negedge clkIn);
    cmp("e1_syncInd", 32'(syncInd), 32'd1);
    cmp("e1_dout",    32'(traceDout), 32'd1);
    cmp("e1_clk",     32'(traceClk), 32'd0);
    cmp("e1_ready",   32'(dif.dataReady), 32'd1);
    @(negedge clkIn);
    cmp("e2_clk_rise", 32'(traceClk), 32'd1);
    repeat (61) @(negedge clkIn);
    cmp("synchi_bit15", 32'(traceDout), 32'd0);
    repeat (2) @(negedge clkIn);
    cmp("halfsync_bit0", 32'(traceDout), 32'd1);
    cmp("halfsync_nosync", 32'(syncInd), 32'd0);

    // Two back-to-back words at 1 bit per edge: pulses 32 cycles apart.
    tx_times.delete();
    apply_stimulus(16'hAA55);
    apply_stimulus(16'h0123);
    repeat (80) @(negedge clkIn);
    cmp("w1_tx_count", 32'(tx_times.size()), 32'd2);
    if (tx_times.size() == 2) cmp("w1_tx_gap", 32'(tx_times[1] - tx_times[0]), 32'd32);

    // 4-bit port: nibbles least significant first, one per trace edge.
    portWidth = 2'd2;
    async_reset();
    fork
      begin
        apply_stimulus(16'h4567);
        apply_stimulus(16'h89AB);
      end
      begin
        wait_tx(100);
        cmp("w4_nib0", 32'(traceDout), 32'h7);
        repeat (2) @(negedge clkIn);
        cmp("w4_nib1", 32'(traceDout), 32'h6);
        repeat (2) @(negedge clkIn);
        cmp("w4_nib2", 32'(traceDout), 32'h5);
        repeat (2) @(negedge clkIn);
        cmp("w4_nib3", 32'(traceDout), 32'h4);
        repeat (2) @(negedge clkIn);
        cmp("w4_tx2",  32'(txInd), 32'd1);
        cmp("w4_nib4", 32'(traceDout), 32'hB);
      end
    join
    repeat (20) @(negedge clkIn);

    // 2-bit port with continuous valid: periodic sync interleaves the data.
    portWidth = 2'd1;
    for (int i = 0; i < 200; i++) begin
      dif.dataValid = 1'b1;
      dif.dataIn    = 16'($urandom);
      @(negedge clkIn);
    end
    dif.dataValid = 1'b0;

    // Width change in the middle of a halfword.
    portWidth = 2'd0;
    repeat (40) @(negedge clkIn);
    repeat (13) @(negedge clkIn);
    portWidth = 2'd3;
    repeat (60) @(negedge clkIn);

    // Reset during a data halfword with another word held: both are lost.
    portWidth = 2'd0;
    apply_stimulus(16'hBEEF);
    wait_tx(200);
    apply_stimulus(16'hCAFE);
    repeat (5) @(negedge clkIn);
    async_reset();
    tx_times.delete();
    repeat (140) @(negedge clkIn);
    cmp("no_stale_tx", 32'(tx_times.size()), 32'd0);

    // Randomized traffic, widths and one asynchronous reset.
    for (int i = 0; i < 2500; i++) begin
      dif.dataValid = ($urandom % 4) != 0;
      dif.dataIn    = 16'($urandom);
      if ($urandom % 23 == 0) portWidth = 2'($urandom);
      if (i == 1200) async_reset();
      else @(negedge clkIn);
    end
    dif.dataValid = 1'b0;
    repeat (10) @(negedge clkIn);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
